// File: rtl/dec_scan_if.sv
// Handshake/decode bus for dec_scan. Optional thermometer select (DEC_SCAN_THERMO_EN).
interface dec_scan_if #(
   parameter int WIDTHI = 3
);
   localparam int WIDTHO = 2**WIDTHI;

   logic              en;
   logic              mode;
   logic [WIDTHI-1:0] in;
   logic              in_valid;
   logic              in_ready;
   logic [WIDTHO-1:0] regout;
   logic              out_valid;
   logic [WIDTHI-1:0] scan_idx;
   logic              wrap;
`ifdef DEC_SCAN_THERMO_EN
   logic              thermo;
`endif

   modport master (
      output en, mode, in, in_valid,
      input  in_ready, regout, out_valid, scan_idx, wrap
`ifdef DEC_SCAN_THERMO_EN
      , output thermo
`endif
   );

   modport slave (
      input  en, mode, in, in_valid,
      output in_ready, regout, out_valid, scan_idx, wrap
`ifdef DEC_SCAN_THERMO_EN
      , input thermo
`endif
   );
endinterface

// File: rtl/dec_scan.sv
// Binary-to-one-hot decoder with direct (handshaked) and auto-scan modes.
// Defining DEC_SCAN_THERMO_EN adds a thermo select for thermometer decoding.
module dec_scan #(
   parameter int WIDTHI = 3,
   parameter int DWELL  = 4
) (
   input  logic       clk,
   input  logic       rst,
   dec_scan_if.slave  bus
);
   localparam int WIDTHO = 2**WIDTHI;
   localparam logic [7:0]        DWELL_LAST = 8'(DWELL - 1);
   localparam logic [WIDTHO-1:0] ZERO_O     = {WIDTHO{1'b0}};
   localparam logic [WIDTHI-1:0] ZERO_I     = {WIDTHI{1'b0}};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2
   } state_t;

   state_t            state_r, state_s;
   logic [WIDTHO-1:0] regout_r, regout_s;
   logic              out_valid_r, out_valid_s;
   logic              wrap_r, wrap_s;
   logic [WIDTHI-1:0] scan_idx_r, scan_idx_s, idx_next_s;
   logic [7:0]        dwell_r, dwell_s;
   logic              in_ready_s;
   logic              thermo_s;

   // Thermometer mode sets bits [k:0]; otherwise only bit k.
   function automatic logic [WIDTHO-1:0] decode(input logic [WIDTHI-1:0] k,
                                                input logic thermo);
      logic [WIDTHO-1:0] v;
      v = ZERO_O;
      for (int i = 0; i < WIDTHO; i++) begin
         v[i] = thermo ? (i <= int'(k)) : (i == int'(k));
      end
      return v;
   endfunction

`ifdef DEC_SCAN_THERMO_EN
   assign thermo_s = bus.thermo;
`else
   assign thermo_s = 1'b0;
`endif

   assign in_ready_s    = (state_r == DIRECT) && bus.en;
   assign idx_next_s    = scan_idx_r + WIDTHI'(1'b1);
   assign bus.in_ready  = in_ready_s;
   assign bus.regout    = regout_r;
   assign bus.out_valid = out_valid_r;
   assign bus.scan_idx  = scan_idx_r;
   assign bus.wrap      = wrap_r;

   // Next-state and next-output logic; disable outranks mode and handshakes.
   always_comb begin
      state_s     = state_r;
      regout_s    = regout_r;
      out_valid_s = 1'b0;
      wrap_s      = 1'b0;
      scan_idx_s  = scan_idx_r;
      dwell_s     = dwell_r;
      if (!bus.en) begin
         state_s    = IDLE;
         regout_s   = ZERO_O;
         scan_idx_s = ZERO_I;
         dwell_s    = 8'd0;
      end else begin
         case (state_r)
            IDLE, DIRECT: begin
               if (bus.mode) begin
                  // Scan entry wins over a same-cycle handshake.
                  state_s     = SCAN;
                  scan_idx_s  = ZERO_I;
                  dwell_s     = 8'd0;
                  regout_s    = decode(ZERO_I, thermo_s);
                  out_valid_s = 1'b1;
               end else if ((state_r == DIRECT) && in_ready_s && bus.in_valid) begin
                  regout_s    = decode(bus.in, thermo_s);
                  out_valid_s = 1'b1;
               end else begin
                  state_s = DIRECT;
               end
            end
            SCAN: begin
               if (!bus.mode) begin
                  state_s    = DIRECT;
                  scan_idx_s = ZERO_I;
                  dwell_s    = 8'd0;
               end else if (dwell_r == DWELL_LAST) begin
                  dwell_s     = 8'd0;
                  scan_idx_s  = idx_next_s;
                  regout_s    = decode(idx_next_s, thermo_s);
                  out_valid_s = 1'b1;
                  wrap_s      = &scan_idx_r;
               end else begin
                  dwell_s = dwell_r + 8'd1;
               end
            end
            default: begin
               state_s    = IDLE;
               regout_s   = ZERO_O;
               scan_idx_s = ZERO_I;
               dwell_s    = 8'd0;
            end
         endcase
      end
   end

   // State and registered outputs, synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         regout_r    <= ZERO_O;
         out_valid_r <= 1'b0;
         wrap_r      <= 1'b0;
         scan_idx_r  <= ZERO_I;
         dwell_r     <= 8'd0;
      end else begin
         state_r     <= state_s;
         regout_r    <= regout_s;
         out_valid_r <= out_valid_s;
         wrap_r      <= wrap_s;
         scan_idx_r  <= scan_idx_s;
         dwell_r     <= dwell_s;
      end
   end
endmodule

// File: doc/dec_scan.md
DEC_SCAN -- requirements
Module: dec_scan

Interface
REQ-001 SHALL have parameter WIDTHI, default 3: binary select width; the output width is WIDTHO = 2**WIDTHI (localparam).
REQ-002 SHALL have parameter DWELL, default 4: cycles each scan step is held, legal range 1..255.
REQ-003 SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, width 1: synchronous, active-high reset.
REQ-005 SHALL have port en, input, width 1: block enable, active-high.
REQ-006 SHALL have port mode, input, width 1: 0 = direct decode, 1 = auto-scan.
REQ-007 SHALL have port in, input, width WIDTHI: direct-mode select value.
REQ-008 SHALL have port in_valid, input, width 1: in is valid this cycle.
REQ-009 SHALL have port in_ready, output, width 1: the block accepts in this cycle.
REQ-010 SHALL have port regout, output, width WIDTHO: registered decoded output.
REQ-011 SHALL have port out_valid, output, width 1: one-cycle pulse, high when regout took a new value this cycle.
REQ-012 SHALL have port scan_idx, output, width WIDTHI: current scan index.
REQ-013 SHALL have port wrap, output, width 1: one-cycle pulse when the scan wraps from WIDTHO-1 to 0.

Function
REQ-014 SHALL implement a three-state FSM with states IDLE, DIRECT and SCAN.
REQ-015 SHALL transition from any state to IDLE on the next edge when en=0.
REQ-016 SHALL transition from IDLE to DIRECT when en=1 and mode=0, and from IDLE to SCAN when en=1 and mode=1.
REQ-017 SHALL transition DIRECT to SCAN when mode=1, and SCAN to DIRECT when mode=0; each transition takes effect on the next edge.
REQ-018 SHALL drive in_ready=1 only while the FSM is in DIRECT and en=1; otherwise in_ready=0.
REQ-019 SHALL, in DIRECT on handshake (in_valid & in_ready), set regout to one-hot(in) with out_valid=1 one cycle after the handshake (latency 1).
REQ-020 SHALL, in DIRECT without a handshake, hold regout unchanged with out_valid=0.
REQ-021 SHALL, on entry to SCAN, load scan_idx=0, load the dwell counter=0, set regout=one-hot(0) and pulse out_valid.
REQ-022 SHALL increment the dwell counter each cycle while in SCAN.
REQ-023 SHALL, when the dwell counter reaches DWELL-1, clear it and advance scan_idx by 1; regout SHALL show one-hot(new scan_idx) on the same edge and out_valid SHALL pulse.
REQ-024 SHALL, on an advance from scan_idx=WIDTHO-1, wrap scan_idx to 0 and pulse wrap for the cycle regout shows bit 0.
REQ-025 SHALL, with DWELL=1, advance every cycle with out_valid continuously high in SCAN.
REQ-026 SHALL, on leaving SCAN for DIRECT, hold regout at its last scan value until the first DIRECT handshake; scan_idx and the dwell counter SHALL reset to 0.
REQ-027 SHALL, on entry to IDLE, clear regout to 0 on that edge with out_valid=0, and clear scan_idx, the dwell counter and wrap.
REQ-028 SHALL give priority en=0 over mode and over any handshake in the same cycle.
REQ-029 SHALL ensure an out-of-range value on in cannot occur by construction, since WIDTHI selects exactly WIDTHO outputs.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, set FSM=IDLE, regout=0, out_valid=0, wrap=0, scan_idx=0, dwell counter=0 and in_ready=0.
REQ-031 SHALL give rst priority over en, mode and handshakes; a reset mid-scan abandons the scan.

Configuration
REQ-032 SHALL, when macro DEC_SCAN_THERMO_EN is defined, add input port thermo (width 1).
REQ-033 SHALL, with DEC_SCAN_THERMO_EN defined and thermo=1, decode value k as regout bits [k:0] all set (thermometer) in both DIRECT and SCAN.
REQ-034 SHALL, with DEC_SCAN_THERMO_EN defined and thermo=0, decode one-hot.
REQ-035 SHALL, without DEC_SCAN_THERMO_EN, have no thermo port and decode one-hot only.

Verification
REQ-036 SHALL cover reset: rst=1 mid-scan at scan_idx=5 -> next cycle regout=0, scan_idx=0, out_valid=0.
REQ-037 SHALL cover direct decode: WIDTHI=3, en=1, mode=0, in=6, in_valid=1 -> next cycle regout=8'b0100_0000, out_valid=1.
REQ-038 SHALL cover scan: DWELL=4, mode=1 -> regout steps 0x01,0x02,...,0x80, each held 4 cycles, followed by 0x01 with wrap=1 after 32 cycles.
REQ-039 SHALL cover disable: en=0 while in_valid=1 and in=2 -> in_ready=0 and regout=0 next cycle.
REQ-040 SHALL cover mode switch: mode 1->0 at scan_idx=3 -> regout holds 0x08 until a handshake with in=1 gives 0x02.
REQ-041 SHALL cover thermometer: DEC_SCAN_THERMO_EN defined, thermo=1, in=3 -> regout=8'b0000_1111.
